// File: rtl/ascon_round_sequencer.sv
// ascon_round_sequencer: sequences the rounds of one ASCON permutation call (p^a or p^b).
// Drives the datapath with a per-round enable, first-round select and round constant,
// and reports the final round and completion to the requesting mode controller.
module ascon_round_sequencer #(
   parameter int unsigned ROUNDS_A = 12,
   parameter int unsigned ROUNDS_B = 6
) (
   input  logic       clock_i,
   input  logic       resetb_i,
   input  logic       start_i,
   input  logic       sel_b_i,
   input  logic       abort_i,
   output logic       busy_o,
   output logic       perm_en_o,
   output logic       perm_init_o,
   output logic [3:0] round_o,
   output logic [7:0] const_o,
   output logic       last_o,
   output logic       done_o
);

   // Elaboration-time parameter legality
   if (ROUNDS_A < 1 || ROUNDS_A > 12) begin : g_bad_rounds_a
      $error("ascon_round_sequencer: ROUNDS_A must be in 1..12");
   end
   if (ROUNDS_B < 1 || ROUNDS_B > ROUNDS_A) begin : g_bad_rounds_b
      $error("ascon_round_sequencer: ROUNDS_B must be in 1..ROUNDS_A");
   end

   localparam logic [3:0] NumA    = 4'(ROUNDS_A);
   localparam logic [3:0] NumB    = 4'(ROUNDS_B);
   localparam logic [3:0] LastRnd = 4'd11;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e     state_q;
   logic [3:0] round_q;
   logic [3:0] num_q;
   logic [3:0] num_sel;

   // Round count requested by the current start, only consumed in IDLE
   always_comb begin
      num_sel = sel_b_i ? NumB : NumA;
   end

   // Control FSM with round counter and registered status outputs
   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         state_q   <= StIdle;
         round_q   <= 4'd0;
         num_q     <= 4'd0;
         busy_o    <= 1'b0;
         perm_en_o <= 1'b0;
         done_o    <= 1'b0;
      end else if (abort_i) begin
         // Abort wins over start and over the final-round transition
         state_q   <= StIdle;
         round_q   <= 4'd0;
         busy_o    <= 1'b0;
         perm_en_o <= 1'b0;
         done_o    <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start_i) begin
                  state_q   <= StRun;
                  num_q     <= num_sel;
                  round_q   <= 4'd12 - num_sel;
                  busy_o    <= 1'b1;
                  perm_en_o <= 1'b1;
               end
            end
            StRun: begin
               if (round_q == LastRnd) begin
                  state_q   <= StDone;
                  perm_en_o <= 1'b0;
                  done_o    <= 1'b1;
               end else begin
                  round_q <= round_q + 4'd1;
               end
            end
            StDone: begin
               state_q <= StIdle;
               busy_o  <= 1'b0;
               done_o  <= 1'b0;
            end
            default: begin
               state_q   <= StIdle;
               busy_o    <= 1'b0;
               perm_en_o <= 1'b0;
               done_o    <= 1'b0;
            end
         endcase
      end
   end

   // Round-dependent outputs decoded from registered state only
   always_comb begin
      round_o     = round_q;
      const_o     = {4'hF - round_q, round_q};
      perm_init_o = (state_q == StRun) && (round_q == 4'd12 - num_q);
      last_o      = (state_q == StRun) && (round_q == LastRnd);
   end

endmodule

// File: tb/tb_ascon_round_sequencer.sv
// tb_ascon_round_sequencer: directed self-checking bench for ascon_round_sequencer.
module tb_ascon_round_sequencer;

   logic       clock;
   logic       resetb;
   logic       start, sel_b, abort;
   logic       busy, perm_en, perm_init, last, done;
   logic [3:0] round;
   logic [7:0] rconst;

   logic       start1, abort1;
   logic       busy1, perm_en1, perm_init1, last1, done1;
   logic [3:0] round1;
   logic [7:0] rconst1;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] const_tab [12] = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
                                  8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};

   ascon_round_sequencer #(.ROUNDS_A(12), .ROUNDS_B(6)) dut (
      .clock_i     (clock),
      .resetb_i    (resetb),
      .start_i     (start),
      .sel_b_i     (sel_b),
      .abort_i     (abort),
      .busy_o      (busy),
      .perm_en_o   (perm_en),
      .perm_init_o (perm_init),
      .round_o     (round),
      .const_o     (rconst),
      .last_o      (last),
      .done_o      (done)
   );

   ascon_round_sequencer #(.ROUNDS_A(1), .ROUNDS_B(1)) dut_min (
      .clock_i     (clock),
      .resetb_i    (resetb),
      .start_i     (start1),
      .sel_b_i     (1'b0),
      .abort_i     (abort1),
      .busy_o      (busy1),
      .perm_en_o   (perm_en1),
      .perm_init_o (perm_init1),
      .round_o     (round1),
      .const_o     (rconst1),
      .last_o      (last1),
      .done_o      (done1)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Flags packed as {busy, perm_en, perm_init, last, done}
   function automatic logic [4:0] flags();
      return {busy, perm_en, perm_init, last, done};
   endfunction

   int cyc;
   int first_done;
   int second_done;
   int seen;

   initial begin
      resetb = 1'b0;
      start = 0; sel_b = 0; abort = 0; start1 = 0; abort1 = 0;
      #3;
      check_val("reset_flags", 32'(flags()), 32'h00);
      check_val("reset_round", 32'(round), 32'h0);
      check_val("reset_const", 32'(rconst), 32'hF0);
      check_val("reset_min_round", 32'(round1), 32'h0);
      @(posedge clock);
      #1 resetb = 1'b1;
      step();

      // p^a: 12 rounds
      start = 1; sel_b = 0;
      step();
      start = 0;
      for (int i = 0; i < 12; i++) begin
         check_val($sformatf("pa_round%0d", i), 32'(round), 32'(i));
         check_val($sformatf("pa_const%0d", i), 32'(rconst), 32'(const_tab[i]));
         check_val($sformatf("pa_flags%0d", i), 32'(flags()),
                   {27'd0, 1'b1, 1'b1, (i == 0), (i == 11), 1'b0});
         step();
      end
      check_val("pa_done", 32'(flags()), 32'b10001);
      check_val("pa_done_round", 32'(round), 32'd11);
      step();
      check_val("pa_idle", 32'(flags()), 32'h00);
      check_val("pa_idle_const", 32'(rconst), 32'h4B);

      // p^b: 6 rounds, with start pulses in RUN and DONE that must be ignored
      start = 1; sel_b = 1;
      step();
      start = 0;
      for (int i = 0; i < 6; i++) begin
         check_val($sformatf("pb_round%0d", i), 32'(round), 32'(6 + i));
         check_val($sformatf("pb_const%0d", i), 32'(rconst), 32'(const_tab[6 + i]));
         check_val($sformatf("pb_flags%0d", i), 32'(flags()),
                   {27'd0, 1'b1, 1'b1, (i == 0), (i == 5), 1'b0});
         start = (i == 2);
         sel_b = 0;
         step();
         start = 0;
      end
      check_val("pb_done", 32'(flags()), 32'b10001);
      start = 1; sel_b = 0;
      step();
      start = 0;
      check_val("pb_start_in_done_ignored", 32'(flags()), 32'h00);
      step();
      check_val("pb_still_idle", 32'(flags()), 32'h00);

      // Held start on p^b: done pulses 8 cycles apart
      start = 1; sel_b = 1;
      first_done = -1; second_done = -1;
      for (int c = 0; c < 30; c++) begin
         step();
         if (done && first_done < 0) first_done = c;
         else if (done && second_done < 0) second_done = c;
      end
      start = 0;
      check_val("held_first_done_seen", 32'(first_done >= 0), 32'd1);
      check_val("held_period", 32'(second_done - first_done), 32'd8);
      cyc = 0;
      while (busy && cyc < 20) begin
         step();
         cyc++;
      end
      check_val("held_drain", 32'(busy), 32'd0);

      // Abort at round 3 of p^a
      start = 1; sel_b = 0;
      step();
      start = 0;
      step(); step(); step();
      check_val("abort_pre_round", 32'(round), 32'd3);
      abort = 1;
      step();
      abort = 0;
      check_val("abort_flags", 32'(flags()), 32'h00);
      check_val("abort_round", 32'(round), 32'd0);
      seen = 0;
      for (int c = 0; c < 14; c++) begin
         step();
         if (done || perm_en) seen = 1;
      end
      check_val("abort_no_done", 32'(seen), 32'd0);

      // Abort together with start in IDLE
      abort = 1; start = 1; sel_b = 1;
      step();
      abort = 0; start = 0;
      check_val("abort_start_idle", 32'(flags()), 32'h00);

      // Asynchronous reset mid-RUN at round 8
      start = 1; sel_b = 0;
      step();
      start = 0;
      for (int c = 0; c < 8; c++) step();
      check_val("rst_pre_round", 32'(round), 32'd8);
      resetb = 1'b0;
      #1;
      check_val("rst_async_flags", 32'(flags()), 32'h00);
      check_val("rst_async_round", 32'(round), 32'd0);
      check_val("rst_async_const", 32'(rconst), 32'hF0);
      step();
      resetb = 1'b1;
      step();
      check_val("rst_after_flags", 32'(flags()), 32'h00);

      // Minimum count instance: single RUN cycle
      start1 = 1;
      step();
      start1 = 0;
      check_val("min_round", 32'(round1), 32'd11);
      check_val("min_const", 32'(rconst1), 32'h4B);
      check_val("min_flags", 32'({busy1, perm_en1, perm_init1, last1, done1}), 32'b11110);
      step();
      check_val("min_done", 32'({busy1, perm_en1, perm_init1, last1, done1}), 32'b10001);
      step();
      check_val("min_idle", 32'({busy1, perm_en1, perm_init1, last1, done1}), 32'b00000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ascon_round_sequencer.md
# ascon_round_sequencer

Control block that sequences the rounds of one ASCON permutation call (p^a or p^b) on behalf of the mode controller. It accepts a start request, counts rounds internally, and drives the permutation datapath with a per-round enable, a first-round select and the 8-bit round constant. It reports the final round and completion back to the requester. It sits between the top-level ASCON FSM and the permutation round logic, and it is the consumer-side counterpart of the generic round/block counters.

## Interface
- ROUNDS_A, 12, round count for p^a; legal range 1..12
- ROUNDS_B, 6, round count for p^b; legal range 1..ROUNDS_A
- clock_i  input  1  system clock, rising-edge active
- resetb_i  input  1  reset, asynchronous, active-low
- start_i  input  1  request one permutation call; sampled only in IDLE
- sel_b_i  input  1  0 = run ROUNDS_A rounds, 1 = run ROUNDS_B rounds; sampled with start_i
- abort_i  input  1  synchronous abort, returns to IDLE
- busy_o  output  1  high in RUN and DONE
- perm_en_o  output  1  datapath state-register enable, high on every RUN cycle
- perm_init_o  output  1  high on first RUN cycle only (datapath loads the external state)
- round_o  output  4  absolute round index r (12-N .. 11)
- const_o  output  8  ASCON round constant for round_o
- last_o  output  1  high on final RUN cycle
- done_o  output  1  one-cycle completion pulse (DONE state)

## Operation
- FSM has three states: IDLE, RUN and DONE. The encoding is free.
- **IDLE**
  - If start_i=1 and abort_i=0: latch N = sel_b_i ? ROUNDS_B : ROUNDS_A, load round register with 12-N, and go to RUN.
  - Otherwise stay in IDLE.
- **RUN**
  - perm_en_o=1.
  - If round_o == 11: go to DONE. Otherwise increment the round register.
  - start_i and sel_b_i are ignored in RUN.
- **DONE**
  - done_o=1 for exactly one cycle, then go to IDLE.
  - start_i is ignored in DONE. The earliest new start is sampled in the following IDLE cycle.
- **Round constant**
  - const_o = {4'hF - round_o, round_o}, computed combinationally from the round register.
  - r=0 gives 8'hF0, r=4 gives 8'hB4, r=6 gives 8'h96, r=11 gives 8'h4B.
- **Outputs by state**
  - perm_init_o = RUN and (round_o == 12-N).
  - last_o = RUN and (round_o == 11).
  - For N=1, perm_init_o and last_o are high in the same single RUN cycle.
  - Outside RUN: round_o holds its last value and const_o follows round_o. perm_en_o, perm_init_o and last_o are 0.
- **Abort**
  - abort_i=1 in any state forces IDLE on the next edge.
  - Abort has priority over start and over the RUN→DONE transition. done_o is never pulsed for an aborted call.
  - Round register is reset to 0 on abort.
- **Width rules**
  - Round register is 4 bits and never exceeds 11.
  - N is stored in 4 bits.
  - Parameter legality is checked at elaboration (assertion or $error).

## Timing
- **Reset values**
  - State = IDLE and round register = 0.
  - busy_o=0, perm_en_o=0, perm_init_o=0, last_o=0, done_o=0.
  - round_o=0 and const_o=8'hF0.
- **Latency**
  - start_i is sampled high at edge k.
  - RUN occupies cycles k..k+N-1. round_o = 12-N is valid after edge k.
  - done_o is high for the cycle after edge k+N.
  - Total from start edge to done_o rising is N+1 edges. Back-to-back call period is N+2 cycles.
- **Datapath contract**
  - The datapath captures round output on each edge where perm_en_o=1, using const_o of that same cycle.
  - Exactly N enabled edges occur per non-aborted call.
- **Reset mid-operation**: resetb_i low at any point immediately forces the reset values, asynchronously. No done_o is produced.
- All outputs are registered or decoded from registered state only, with no combinational path from inputs to outputs.

## Test plan
- **Reset**: assert resetb_i mid-RUN (round_o=8) → all outputs return to reset values at once; round_o=0, const_o=8'hF0.
- **p^a**: start_i=1, sel_b_i=0 → 12 RUN cycles.
  - round_o steps 0..11 and const_o steps F0,E1,D2,C3,B4,A5,96,87,78,69,5A,4B.
  - perm_init_o is high on cycle 1 only; last_o is high on cycle 12.
  - done_o is high one cycle later.
- **p^b**: start_i=1, sel_b_i=1 → 6 RUN cycles with round_o 6..11 and const_o 96,87,78,69,5A,4B; done_o at edge 7.
- **Ignored requests**: pulse start_i during RUN and during DONE → no restart and no extra rounds. A start held high produces calls with a period of 8 cycles for p^b.
- **Abort**: abort_i=1 at round_o=3 of p^a → IDLE next cycle, perm_en_o=0, no done_o. abort_i together with start_i in IDLE → stays in IDLE.
- **Minimum count**: ROUNDS_A=ROUNDS_B=1 → one RUN cycle with round_o=11, const_o=4B, and perm_init_o=last_o=1; done_o on the next cycle.
